// File: rtl/mnist_infer_sched.sv
// rtl/mnist_infer_sched.sv - MNIST inference scheduler: pixel load, engine kick-off, argmax result
module mnist_infer_sched #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
    parameter int N_PIXELS = 400,
    parameter int N_OUT = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        abort,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [DATA_WIDTH-1:0]       pix_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [3:0]                  res_class,
    output logic [DATA_WIDTH-1:0]       res_score,
    output logic                        busy,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic                        mem_we,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    output logic                        dnn_start,
    output logic                        dnn_reset,
    input  logic                        dnn_done,
    input  logic [ADDR_WIDTH-1:0]       dnn_addr,
    input  logic [N_OUT*DATA_WIDTH-1:0] dnn_out
);

    localparam int CW = $clog2(N_PIXELS);
    localparam logic [CW-1:0] LAST_PIX = CW'(N_PIXELS - 1);
    localparam logic [3:0] LAST_IDX = 4'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_START, S_RUN, S_ARG, S_RESULT
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]                cnt;
    logic [3:0]                   idx;
    logic [3:0]                   best_idx;
    logic signed [DATA_WIDTH-1:0] best_score;
    logic signed [DATA_WIDTH-1:0] scores [N_OUT];
    logic [ADDR_WIDTH-1:0]        mem_addr_q;
    logic                         pix_hs;
    logic                         last_pix;

    assign pix_ready = (state == S_LOAD) && !abort;
    assign pix_hs    = pix_valid && pix_ready;
    assign last_pix  = pix_hs && (cnt == LAST_PIX);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_RESULT);
    assign res_class = best_idx;
    assign res_score = best_score;
    // The engine owns the address port only while it is running.
    assign mem_addr  = (state == S_RUN) ? dnn_addr : mem_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pix_valid) state_nxt = S_LOAD;
            S_LOAD:   if (last_pix) state_nxt = S_CLR;
            S_CLR:    state_nxt = S_START;
            S_START:  state_nxt = S_RUN;
            S_RUN:    if (dnn_done) state_nxt = S_ARG;
            S_ARG:    if (idx == LAST_IDX) state_nxt = S_RESULT;
            S_RESULT: if (res_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            best_idx   <= '0;
            best_score <= '0;
            mem_addr_q <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            dnn_start  <= 1'b0;
            dnn_reset  <= 1'b0;
            for (int i = 0; i < N_OUT; i++) scores[i] <= '0;
        end else begin
            mem_we    <= 1'b0;
            dnn_start <= 1'b0;
            dnn_reset <= 1'b0;
            if (abort) begin
                // Soft-reset the engine so a cancelled run leaves nothing behind.
                cnt       <= '0;
                dnn_reset <= 1'b1;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (pix_hs) begin
                            mem_we     <= 1'b1;
                            mem_addr_q <= ADDR_BASE_A + ADDR_WIDTH'(cnt);
                            mem_wdata  <= pix_data;
                            cnt        <= last_pix ? '0 : cnt + CW'(1);
                            dnn_reset  <= last_pix;
                        end
                    end
                    S_CLR: dnn_start <= 1'b1;
                    S_RUN: begin
                        mem_addr_q <= dnn_addr;
                        if (dnn_done) begin
                            for (int i = 0; i < N_OUT; i++)
                                scores[i] <= dnn_out[i*DATA_WIDTH +: DATA_WIDTH];
                            best_idx   <= '0;
                            best_score <= dnn_out[DATA_WIDTH-1:0];
                            idx        <= 4'd1;
                        end
                    end
                    S_ARG: begin
                        // Strictly greater keeps the lowest index on ties.
                        if (scores[idx] > best_score) begin
                            best_idx   <= idx;
                            best_score <= scores[idx];
                        end
                        idx <= idx + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/mnist_infer_sched.md
# mnist_infer_sched

Inference scheduler for the fixed-point MNIST engine. It owns the single-port activation/weight memory and streams one 400-pixel image from a host into the activation region. It then soft-resets and starts the DNN engine, hands it the memory address port, and waits for completion. Finally it reduces the 10 class outputs to an argmax result delivered over a valid/ready handshake.

## Interface
- DATA_WIDTH, 14, signed fixed-point word width of pixels and class scores
- ADDR_WIDTH, 16, memory address width
- ADDR_BASE_A, 16'h0000, first address of the activation region
- N_PIXELS, 400, pixels per image
- N_OUT, 10, number of DNN class outputs
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- abort  in  1  synchronous cancel of the current job
- pix_valid  in  1  host pixel valid
- pix_ready  out  1  scheduler accepts a pixel
- pix_data  in  DATA_WIDTH  pixel value
- res_valid  out  1  result available
- res_ready  in  1  host consumes result
- res_class  out  4  winning class index
- res_score  out  DATA_WIDTH  winning class score, signed
- busy  out  1  high in any state except IDLE
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_WIDTH  memory write data
- dnn_start  out  1  one-cycle start pulse to the engine
- dnn_reset  out  1  one-cycle synchronous soft reset to the engine
- dnn_done  in  1  engine completion
- dnn_addr  in  ADDR_WIDTH  engine read address
- dnn_out  in  N_OUT x DATA_WIDTH  signed engine class outputs

## Operation
- **States:** IDLE, LOAD, CLR, START, RUN, ARG, RESULT.
- **IDLE:** on the first cycle with pix_valid=1, go to LOAD. No pixel is accepted in IDLE.
- **LOAD:** pix_ready = (state==LOAD) && !abort.
  - Each handshake registers mem_we=1, mem_addr=ADDR_BASE_A+cnt, mem_wdata=pix_data for the next cycle, then increments cnt.
  - With no handshake, mem_we=0.
  - The handshake with cnt==N_PIXELS-1 moves the FSM to CLR.
- **CLR:** dnn_reset=1 for exactly one cycle, then go to START.
- **START:** dnn_start=1 for exactly one cycle, then go to RUN.
- **RUN:** mem_addr = dnn_addr combinationally and mem_we=0.
  - The first cycle with dnn_done=1 snapshots dnn_out into an internal N_OUT-entry register and moves to ARG.
  - dnn_done is ignored in every other state.
- **ARG:** sequential argmax, one compare per cycle over indices 1..N_OUT-1, starting from best=index 0.
  - Replace best only on strictly greater (signed compare), so ties resolve to the lowest index.
  - After N_OUT-1 cycles, go to RESULT.
- **RESULT:** res_valid=1, with res_class and res_score held stable until res_valid && res_ready. On that handshake, go to IDLE.
- **abort:**
  - Takes effect in any state and has priority over every other event, including a same-cycle pixel handshake or dnn_done.
  - The next cycle the FSM is in IDLE, cnt=0, res_valid=0, mem_we=0, and dnn_reset=1 for that single cycle.
  - A pixel presented in the abort cycle is not accepted.

## Timing
- **Reset (rst=0):** state IDLE, cnt=0, and every output is 0: pix_ready, res_valid, res_class, res_score, busy, mem_addr, mem_we, mem_wdata, dnn_start, dnn_reset.
- **Memory write latency:** a pixel handshake at cycle t writes at cycle t+1.
- **Load sequence:** the last handshake at cycle T gives:
  - T+1: last write, and state CLR with dnn_reset=1.
  - T+2: dnn_start=1.
  - T+3 onward: RUN.
- **Result latency:** dnn_done sampled at cycle D gives ARG over D+1..D+N_OUT-1 and res_valid=1 from D+N_OUT.
- **Minimum job length:** N_PIXELS handshakes, plus 2 cycles, plus engine time, plus N_OUT cycles, plus 1 result handshake cycle.
- **Back-to-back jobs:** a host holding pix_valid=1 while the result is consumed sees pix_ready rise 2 cycles after the result handshake (IDLE, then LOAD).
- **Interval rules:**
  - Outside LOAD and RUN, mem_addr holds its last value and mem_we=0.
  - dnn_start and dnn_reset are never high in the same cycle.

## Test plan
- **Full job:** 400 pixels with pix_data=index, no stalls, then dnn_done 50 cycles after start with dnn_out={3,-2,7,100,-500,99,0,100,5,1} -> memory addresses 0..399 hold 0..399, and res_class=3, res_score=100 (tie with index 7 resolves low), res_valid exactly 10 cycles after dnn_done.
- **Bursty host:** pix_valid toggles randomly and pix_ready is checked -> exactly 400 writes, contiguous addresses, no duplicates or gaps, and dnn_start is a single pulse 2 cycles after the last handshake.
- **All-negative outputs:** dnn_out={-8,-3,-9,...,-3} -> res_class=1, res_score=-3.
- **Result backpressure:** res_ready held low 20 cycles -> res_valid and res_score stable throughout, one handshake, then IDLE, and a second job completes correctly.
- **Abort mid-LOAD (cnt=137) and mid-RUN:** -> next cycle IDLE, dnn_reset pulse, no res_valid; the following full job writes from address 0 and produces the correct result.
- **Async reset mid-ARG, plus spurious dnn_done in IDLE/LOAD:** -> all outputs 0 immediately on reset; spurious done causes no state change.
